pic_host_sequencer: RTL
=======================

# pic_host_sequencer

CPU-side bus sequencer that drives the interrupt controller from the host side. It runs the ICW1–ICW4 programming writes (WR/A0/data strobes). After initialization it services INTR by issuing the two-pulse INTA acknowledge and capturing the interrupt vector the controller drives on the data bus. It sits between the host core and the PIC's data-bus buffer and read/write logic.

## Interface
Parameters:
- STROBE_CYCLES, 2: low width of each WR and INTA pulse, in clk cycles (≥1)
- GAP_CYCLES, 2: high time after each write and between INTA pulses (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- init_start  in  1  one-cycle request to run ICW programming
- icw1_in, icw2_in, icw3_in, icw4_in  in  8 each  ICW values, captured when init_start is accepted
- init_busy  out  1  high while the programming sequence runs
- init_done  out  1  one-cycle pulse when the sequence completes
- configured  out  1  high after a completed sequence; cleared by rst or an accepted init_start
- INTR  in  1  interrupt request from the PIC, active-high
- INTA  out  1  interrupt acknowledge, active-low
- WR  out  1  write strobe, active-low
- A0  out  1  register select; 0 for ICW1, 1 for ICW2–ICW4
- data_out  out  8  write data to the PIC
- data_oe  out  1  host drives data bus when 1
- data_in  in  8  data bus from the PIC (vector)
- vector  out  8  last captured vector
- vector_valid  out  1  one-cycle pulse when vector updates

## Operation
- Reset values: INTA=1, WR=1, A0=0, data_out=0, data_oe=0, vector=0, vector_valid=0, init_busy=0, init_done=0, configured=0, state=IDLE.
- States:
  - Write path: IDLE, W_SETUP, W_STROBE, W_HOLD, W_GAP.
  - Acknowledge path: A_P1, A_GAP, A_P2, A_END.
- Write list is built from the captured icw1:
  - ICW1 and ICW2 are always written.
  - ICW3 is written only if icw1[1]==0 (cascade).
  - ICW4 is written only if icw1[0]==1 (IC4).
  - Order is ICW1, ICW2, ICW3, ICW4, skipping absent words.
- Each write takes four phases:
  - W_SETUP, 1 cycle: data_oe=1, data_out=word, A0 valid, WR=1.
  - W_STROBE, STROBE_CYCLES: WR=0.
  - W_HOLD, 1 cycle: WR=1, data and A0 held.
  - W_GAP, GAP_CYCLES: data_oe=0. Then go to the next word's W_SETUP, or finish.
- Finish: return to IDLE. In the first IDLE cycle, init_done pulses, configured=1 and init_busy=0.
- In IDLE, configured=1 and INTR=1 start the acknowledge sequence:
  - A_P1, STROBE_CYCLES: INTA=0.
  - A_GAP, GAP_CYCLES: INTA=1.
  - A_P2, STROBE_CYCLES: INTA=0. data_in is sampled on the last A_P2 cycle.
  - A_END, GAP_CYCLES: INTA=1. vector is updated and vector_valid pulses in the first A_END cycle.
  - Then return to IDLE.
- data_oe stays 0 throughout the acknowledge sequence.
- Priority in IDLE: init_start beats INTR.
- init_start outside IDLE is ignored. INTR outside IDLE, or while configured=0, is ignored; it is level-sampled again in IDLE.
- INTR dropping mid-acknowledge does not abort the sequence; both pulses are always completed.
- rst asserted in any state returns all outputs to reset values on the next edge. No partial strobe is extended.

## Timing
- init_start sampled at edge N: W_SETUP in cycle N+1, and init_busy=1 from N+1.
- Per-word cost: 2+STROBE_CYCLES+GAP_CYCLES cycles. With defaults that is 6.
- Defaults, 3-word sequence:
  - WR low in cycles N+2..N+3, N+8..N+9, N+14..N+15.
  - init_done in cycle N+19.
- INTR sampled high at edge M (defaults):
  - INTA low in M+1..M+2 and M+5..M+6.
  - data_in captured at edge M+7.
  - vector_valid in M+7.
  - IDLE again at M+9.
- A0 and data_out are stable from W_SETUP through W_HOLD, covering one cycle of setup and one cycle of hold around WR low.

## Test plan
- rst, then icw1=0x13, icw2=0x40, icw4=0x01, init_start -> 3 WR pulses, A0 0/1/1, data 0x13/0x40/0x01, init_done at N+19, configured=1.
- icw1=0x11, icw3=0x04 -> 4 writes: 0x11, icw2, 0x04, icw4. icw1=0x12 -> 2 writes only. Check WR low width = STROBE_CYCLES every time.
- INTR=1 with configured=0 -> INTA stays 1 for 50 cycles.
- Configured, INTR=1, PIC model drives data_in=0x45 during the second INTA pulse -> exactly 2 INTA pulses of 2 cycles, vector=0x45, one vector_valid pulse. Drop INTR after the first pulse -> second pulse still occurs.
- Configured, init_start and INTR both high in the same IDLE cycle -> write sequence runs, no INTA, and configured drops to 0 until init_done.
- rst asserted during W_STROBE, and separately during A_P1 -> next cycle WR=1, INTA=1, data_oe=0, init_busy=0, configured=0, state IDLE.

Source files
------------

// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259-style interrupt controller: runs the
// ICW1..ICW4 write sequence and services INTR with a two-pulse INTA cycle.
module pic_host_sequencer #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  input  logic [7:0] icw1_in,
  input  logic [7:0] icw2_in,
  input  logic [7:0] icw3_in,
  input  logic [7:0] icw4_in,
  output logic       init_busy,
  output logic       init_done,
  output logic       configured,
  input  logic       INTR,
  output logic       INTA,
  output logic       WR,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  output logic [7:0] vector,
  output logic       vector_valid
);

  localparam int unsigned MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, W_GAP, A_P1, A_GAP, A_P2, A_END
  } state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_words [4];
  logic [1:0]       r_last_idx;
  logic [1:0]       r_idx;
  logic [7:0]       w_list [4];
  logic [1:0]       w_list_last;
  logic             w_accept;
  logic             w_adv;
  logic             w_seq_end;
  logic             w_capture;

  logic       r_wr, r_inta, r_a0, r_oe, r_busy, r_done, r_cfg, r_vv;
  logic [7:0] r_dout, r_vector;

  // Compact write list from ICW1 flags: cascade (bit1==0) adds ICW3, IC4 adds ICW4
  always_comb begin
    w_list[0]   = icw1_in;
    w_list[1]   = icw2_in;
    w_list[2]   = icw3_in;
    w_list[3]   = icw4_in;
    w_list_last = 2'd1;
    if (!icw1_in[1]) begin
      w_list_last = 2'd2;
      if (icw1_in[0]) begin
        w_list_last = 2'd3;
      end
    end else if (icw1_in[0]) begin
      w_list[2]   = icw4_in;
      w_list_last = 2'd2;
    end
  end

  // Next-state logic with per-phase cycle counter
  always_comb begin
    w_nxt_state = r_state;
    w_cnt_nxt   = '0;
    w_accept    = 1'b0;
    w_adv       = 1'b0;
    w_seq_end   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (init_start) begin
          w_nxt_state = W_SETUP;
          w_accept    = 1'b1;
        end else if (r_cfg && INTR) begin
          w_nxt_state = A_P1;
        end
      end
      W_SETUP: w_nxt_state = W_STROBE;
      W_STROBE: begin
        if (r_cnt == STB_LAST) w_nxt_state = W_HOLD;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      W_HOLD: w_nxt_state = W_GAP;
      W_GAP: begin
        if (r_cnt == GAP_LAST) begin
          if (r_idx == r_last_idx) begin
            w_nxt_state = IDLE;
            w_seq_end   = 1'b1;
          end else begin
            w_nxt_state = W_SETUP;
            w_adv       = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      A_P1: begin
        if (r_cnt == STB_LAST) w_nxt_state = A_GAP;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      A_GAP: begin
        if (r_cnt == GAP_LAST) w_nxt_state = A_P2;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      A_P2: begin
        if (r_cnt == STB_LAST) begin
          w_nxt_state = A_END;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      A_END: begin
        if (r_cnt == GAP_LAST) w_nxt_state = IDLE;
        else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // State and phase counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Bus strobes and status flags, registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= 1'b1;
      r_inta <= 1'b1;
      r_oe   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cfg  <= 1'b0;
    end else begin
      r_wr   <= (w_nxt_state != W_STROBE);
      r_inta <= !((w_nxt_state == A_P1) || (w_nxt_state == A_P2));
      r_oe   <= (w_nxt_state == W_SETUP) || (w_nxt_state == W_STROBE) || (w_nxt_state == W_HOLD);
      r_busy <= (w_nxt_state == W_SETUP) || (w_nxt_state == W_STROBE) ||
                (w_nxt_state == W_HOLD)  || (w_nxt_state == W_GAP);
      r_done <= w_seq_end;
      if (w_seq_end)     r_cfg <= 1'b1;
      else if (w_accept) r_cfg <= 1'b0;
    end
  end

  // Word list, write data/A0 and captured vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_words    <= '{default: '0};
      r_last_idx <= '0;
      r_idx      <= '0;
      r_dout     <= '0;
      r_a0       <= 1'b0;
      r_vector   <= '0;
      r_vv       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_words    <= w_list;
        r_last_idx <= w_list_last;
        r_idx      <= '0;
        r_dout     <= icw1_in;
        r_a0       <= 1'b0;
      end else if (w_adv) begin
        r_idx  <= r_idx + 2'd1;
        r_dout <= r_words[r_idx + 2'd1];
        r_a0   <= 1'b1;
      end
      r_vv <= w_capture;
      if (w_capture) r_vector <= data_in;
    end
  end

  assign WR           = r_wr;
  assign INTA         = r_inta;
  assign A0           = r_a0;
  assign data_out     = r_dout;
  assign data_oe      = r_oe;
  assign init_busy    = r_busy;
  assign init_done    = r_done;
  assign configured   = r_cfg;
  assign vector       = r_vector;
  assign vector_valid = r_vv;

endmodule
